loop_pc_unit: RTL and testbench

- Program-counter and loop-branch stage sitting directly downstream of the loop register in the downsampling processor datapath.
- Consumes the loop register's zero flag and issues that register's decrement strobe, so that a "jump-if-loop-nonzero" instruction both branches and decrements in one cycle.
- Also provides load-from-bus, increment, unconditional jump, and a small call/return stack for pixel-row subroutines.
- Drives the instruction-memory address and a 16-bit readback onto the shared bus.

---
 rtl/loop_pc_unit_pkg.sv | 42 ++++
 rtl/loop_pc_unit_stack.sv | 60 ++++++
 rtl/loop_pc_unit.sv | 94 +++++++++
 tb/tb_loop_pc_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/loop_pc_unit_pkg.sv
// Shared definitions for the loop/PC stage: default sizes, the command
// priority enum and the decoder that picks one winning command per cycle.
package loop_pc_unit_pkg;

    localparam int DEF_PC_W        = 8;
    localparam int DEF_STACK_DEPTH = 4;

    // Stack pointer must represent 0..depth inclusive, hence one extra bit.
    function automatic int sp_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int DEF_SP_W = sp_width(DEF_STACK_DEPTH);

    // Listed in decreasing priority after CMD_NONE.
    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_LOAD,
        CMD_RET,
        CMD_CALL,
        CMD_JMP,
        CMD_JNZ,
        CMD_INC
    } cmd_e;

    // Fixed-priority pick: pc_we > ret > call > jmp > jnz > inc.
    function automatic cmd_e cmd_decode(input logic pc_we,
                                        input logic ret,
                                        input logic call,
                                        input logic jmp,
                                        input logic jnz,
                                        input logic inc);
        if (pc_we)     return CMD_LOAD;
        else if (ret)  return CMD_RET;
        else if (call) return CMD_CALL;
        else if (jmp)  return CMD_JMP;
        else if (jnz)  return CMD_JNZ;
        else if (inc)  return CMD_INC;
        else           return CMD_NONE;
    endfunction

endpackage

// File: rtl/loop_pc_unit_stack.sv
// LIFO of return addresses for subroutine calls. Owns the storage, the
// stack pointer, the full/empty flags and the sticky overflow/underflow flag.
module pc_return_stack
    import loop_pc_unit_pkg::*;
#(
    parameter int DEPTH  = DEF_STACK_DEPTH,
    parameter int DATA_W = DEF_PC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty,
    output logic              err
);

    localparam int SP_W  = sp_width(DEPTH);
    localparam int IDX_W = SP_W - 1;

    logic [SP_W-1:0]   sp;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic [DATA_W-1:0] mem [DEPTH];

    assign full   = (sp == SP_W'(DEPTH));
    assign empty  = (sp == '0);
    assign wr_idx = IDX_W'(sp);
    assign rd_idx = IDX_W'(sp - SP_W'(1));

    // Top of stack is always presented; only meaningful when not empty.
    assign pop_data = mem[rd_idx];

    // Stack pointer and sticky error: a push when full or a pop when empty
    // changes nothing except latching the error.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            sp  <= '0;
            err <= 1'b0;
        end else if (push) begin
            if (full) err <= 1'b1;
            else      sp  <= sp + SP_W'(1);
        end else if (pop) begin
            if (empty) err <= 1'b1;
            else       sp  <= sp - SP_W'(1);
        end
    end

    // Storage write on a successful push.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately left out of reset; entries
        // above sp are never read, so resetting them would only cost logic.
        if (push && !full) mem[wr_idx] <= push_data;
    end

endmodule

// File: rtl/loop_pc_unit.sv
// Program counter and loop-branch stage: picks one command per cycle,
// updates the PC register, drives the loop register decrement strobe and
// hosts the call/return stack.
module loop_pc_unit
    import loop_pc_unit_pkg::*;
#(
    parameter int PC_W        = DEF_PC_W,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [15:0]     bus_to_pc,
    input  logic            pc_we,
    input  logic            inc,
    input  logic            jmp,
    input  logic            jnz,
    input  logic            call,
    input  logic            ret,
    input  logic [PC_W-1:0] jmp_target,
    input  logic            lrz_flag,
    output logic [PC_W-1:0] pc_addr,
    output logic [15:0]     pc_to_bus,
    output logic            lr_decrement,
    output logic            stack_full,
    output logic            stack_empty,
    output logic            stack_err
);

    cmd_e            cmd;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] pc_plus1;
    logic [PC_W-1:0] pop_data;
    logic            push;
    logic            pop;
    logic            unused_bus;

    // Only the low PC_W bits of the bus are loadable.
    assign unused_bus = &{1'b0, bus_to_pc};

    assign pc_plus1  = pc + PC_W'(1);
    assign pc_addr   = pc;
    assign pc_to_bus = 16'(pc);

    // Single winning command for this cycle.
    always_comb begin
        cmd = cmd_decode(pc_we, ret, call, jmp, jnz, inc);
    end

    assign push = (cmd == CMD_CALL);
    assign pop  = (cmd == CMD_RET);

    // The loop register decrements on the same edge the branch is taken;
    // held low during reset so a stray jnz cannot disturb it.
    assign lr_decrement = rst_n && (cmd == CMD_JNZ) && !lrz_flag;

    // Next-PC selection; failed call/ret leave the PC where it is.
    always_comb begin
        // NOTE: defaulting pc_next first guarantees every path assigns it,
        // so no latch is inferred for unlisted or failing cases.
        pc_next = pc;
        case (cmd)
            CMD_LOAD: pc_next = bus_to_pc[PC_W-1:0];
            CMD_RET:  if (!stack_empty) pc_next = pop_data;
            CMD_CALL: if (!stack_full)  pc_next = jmp_target;
            CMD_JMP:  pc_next = jmp_target;
            CMD_JNZ:  pc_next = lrz_flag ? pc_plus1 : jmp_target;
            CMD_INC:  pc_next = pc_plus1;
            default:  pc_next = pc;
        endcase
    end

    // PC register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= '0;
        else        pc <= pc_next;
    end

    pc_return_stack #(
        .DEPTH  (STACK_DEPTH),
        .DATA_W (PC_W)
    ) u_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .push_data (pc_plus1),
        .pop_data  (pop_data),
        .full      (stack_full),
        .empty     (stack_empty),
        .err       (stack_err)
    );

endmodule

// File: tb/tb_loop_pc_unit.sv
// Scoreboard bench for loop_pc_unit: the driver queues the expected state
// for every command it issues, and a monitor compares after each edge.
module tb_loop_pc_unit;
    import loop_pc_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] bus_to_pc;
    logic        pc_we, inc, jmp, jnz, call, ret, lrz_flag;
    logic [7:0]  jmp_target;
    logic [7:0]  pc_addr;
    logic [15:0] pc_to_bus;
    logic        lr_decrement, stack_full, stack_empty, stack_err;

    typedef struct {
        int         id;
        logic [7:0] pc;
        logic       lr;
        logic       full;
        logic       empty;
        logic       err;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   step_id  = 0;
    logic lr_pre;

    loop_pc_unit #(.PC_W(8), .STACK_DEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus_to_pc    (bus_to_pc),
        .pc_we        (pc_we),
        .inc          (inc),
        .jmp          (jmp),
        .jnz          (jnz),
        .call         (call),
        .ret          (ret),
        .jmp_target   (jmp_target),
        .lrz_flag     (lrz_flag),
        .pc_addr      (pc_addr),
        .pc_to_bus    (pc_to_bus),
        .lr_decrement (lr_decrement),
        .stack_full   (stack_full),
        .stack_empty  (stack_empty),
        .stack_err    (stack_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", what, act, exp);
        end
    endtask

    // The strobe is combinational from this cycle's inputs; sample it late in
    // the low phase, just before the edge that consumes it.
    always @(negedge clk) begin
        #4;
        lr_pre = lr_decrement;
    end

    // Monitor: after each rising edge, retire one queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check($sformatf("step%0d pc_addr", e.id), 32'(pc_addr), 32'(e.pc));
                check($sformatf("step%0d pc_to_bus", e.id), 32'(pc_to_bus), {24'h0, e.pc});
                check($sformatf("step%0d lr_decrement", e.id), 32'(lr_pre), 32'(e.lr));
                check($sformatf("step%0d stack_full", e.id), 32'(stack_full), 32'(e.full));
                check($sformatf("step%0d stack_empty", e.id), 32'(stack_empty), 32'(e.empty));
                check($sformatf("step%0d stack_err", e.id), 32'(stack_err), 32'(e.err));
            end
        end
    end

    task automatic clear_inputs();
        bus_to_pc  = 16'h0;
        pc_we      = 1'b0;
        inc        = 1'b0;
        jmp        = 1'b0;
        jnz        = 1'b0;
        call       = 1'b0;
        ret        = 1'b0;
        jmp_target = 8'h0;
        lrz_flag   = 1'b0;
    endtask

    // Drive one cycle of commands and queue the expected post-edge state.
    task automatic step(input logic [15:0] bus, input logic we, input logic r,
                        input logic c, input logic j, input logic jz, input logic i,
                        input logic [7:0] tgt, input logic lz,
                        input logic [7:0] e_pc, input logic e_lr, input logic e_full,
                        input logic e_empty, input logic e_err);
        exp_t e;
        @(negedge clk);
        bus_to_pc  = bus;
        pc_we      = we;
        ret        = r;
        call       = c;
        jmp        = j;
        jnz        = jz;
        inc        = i;
        jmp_target = tgt;
        lrz_flag   = lz;
        step_id++;
        e.id = step_id; e.pc = e_pc; e.lr = e_lr;
        e.full = e_full; e.empty = e_empty; e.err = e_err;
        sb_q.push_back(e);
    endtask

    // Assert reset between edges (optionally with a call pending) and check
    // that state clears immediately, then release on a later falling edge.
    task automatic reset_pulse(input logic with_call, input string tag);
        @(negedge clk);
        clear_inputs();
        call       = with_call;
        jmp_target = 8'hAA;
        #1 rst_n = 1'b0;
        #1;
        check({tag, " pc_addr"}, 32'(pc_addr), 32'h0);
        check({tag, " pc_to_bus"}, 32'(pc_to_bus), 32'h0);
        check({tag, " stack_empty"}, 32'(stack_empty), 32'h1);
        check({tag, " stack_full"}, 32'(stack_full), 32'h0);
        check({tag, " stack_err"}, 32'(stack_err), 32'h0);
        check({tag, " lr_decrement"}, 32'(lr_decrement), 32'h0);
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b1;
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        // jnz with a nonzero loop register during reset must not strobe.
        jnz = 1'b1;
        #12;
        check("reset pc_addr", 32'(pc_addr), 32'h0);
        check("reset pc_to_bus", 32'(pc_to_bus), 32'h0);
        check("reset stack_empty", 32'(stack_empty), 32'h1);
        check("reset stack_full", 32'(stack_full), 32'h0);
        check("reset stack_err", 32'(stack_err), 32'h0);
        check("reset lr_decrement", 32'(lr_decrement), 32'h0);
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b1;

        //    bus       we  r  c  j  jz i  tgt    lz   pc     lr full emp err
        step(16'h0000, 0, 0, 0, 0, 0, 1, 8'h00, 0, 8'h01, 0, 0, 1, 0);
        step(16'h0000, 0, 0, 0, 0, 0, 1, 8'h00, 0, 8'h02, 0, 0, 1, 0);
        step(16'h0000, 0, 0, 0, 0, 0, 1, 8'h00, 0, 8'h03, 0, 0, 1, 0);
        step(16'h00FF, 1, 0, 0, 0, 0, 0, 8'h00, 0, 8'hFF, 0, 0, 1, 0);
        step(16'h0000, 0, 0, 0, 0, 0, 1, 8'h00, 0, 8'h00, 0, 0, 1, 0);
        step(16'hAB12, 1, 0, 0, 1, 0, 1, 8'h77, 0, 8'h12, 0, 0, 1, 0);
        step(16'h0010, 1, 0, 0, 0, 0, 0, 8'h00, 0, 8'h10, 0, 0, 1, 0);
        // Three-iteration loop back to 0x08.
        step(16'h0000, 0, 0, 0, 0, 1, 0, 8'h08, 0, 8'h08, 1, 0, 1, 0);
        step(16'h0000, 0, 0, 0, 0, 1, 0, 8'h08, 0, 8'h08, 1, 0, 1, 0);
        step(16'h0000, 0, 0, 0, 0, 1, 0, 8'h08, 1, 8'h09, 0, 0, 1, 0);
        // jnz masked by pc_we: no strobe, bus load wins.
        step(16'h0033, 1, 0, 0, 0, 1, 0, 8'h08, 0, 8'h33, 0, 0, 1, 0);
        step(16'h0000, 0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h33, 0, 0, 1, 0);
        // jmp beats jnz and inc.
        step(16'h0000, 0, 0, 0, 1, 1, 1, 8'h20, 0, 8'h20, 0, 0, 1, 0);
        // Nested call / return, then underflow.
        step(16'h0000, 0, 0, 1, 0, 0, 0, 8'h40, 0, 8'h40, 0, 0, 0, 0);
        step(16'h0000, 0, 0, 1, 0, 0, 0, 8'h50, 0, 8'h50, 0, 0, 0, 0);
        step(16'h0000, 0, 1, 0, 0, 0, 0, 8'h00, 0, 8'h41, 0, 0, 0, 0);
        step(16'h0000, 0, 1, 0, 0, 0, 0, 8'h00, 0, 8'h21, 0, 0, 1, 0);
        step(16'h0000, 0, 1, 0, 0, 0, 0, 8'h00, 0, 8'h21, 0, 0, 1, 1);

        reset_pulse(1'b0, "rst1");

        // Fill the stack, then overflow.
        step(16'h0000, 0, 0, 1, 0, 0, 0, 8'h60, 0, 8'h60, 0, 0, 0, 0);
        step(16'h0000, 0, 0, 1, 0, 0, 0, 8'h61, 0, 8'h61, 0, 0, 0, 0);
        step(16'h0000, 0, 0, 1, 0, 0, 0, 8'h62, 0, 8'h62, 0, 0, 0, 0);
        step(16'h0000, 0, 0, 1, 0, 0, 0, 8'h63, 0, 8'h63, 0, 1, 0, 0);
        step(16'h0000, 0, 0, 1, 0, 0, 0, 8'h70, 0, 8'h63, 0, 1, 0, 1);
        step(16'h0000, 0, 1, 0, 0, 0, 0, 8'h00, 0, 8'h63, 0, 0, 0, 1);

        // Reset with a call pending: nothing must be pushed.
        reset_pulse(1'b1, "rst2");
        step(16'h0000, 0, 1, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 1, 1);
        // Wrap through jnz fall-through at the top of the address space.
        step(16'h00FF, 1, 0, 0, 0, 0, 0, 8'h00, 0, 8'hFF, 0, 0, 1, 1);
        step(16'h0000, 0, 0, 0, 0, 1, 0, 8'h08, 1, 8'h00, 0, 0, 1, 1);

        @(negedge clk);
        clear_inputs();
        for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(posedge clk);
        #2;
        check("scoreboard drained", 32'(sb_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
